// File: rtl/lampfpu_sqrt_sched_pkg.sv
// Shared float format constants, the canonical quiet NaN, scheduler defaults
// and the scheduler FSM state type for the lampFPU sqrt scheduler.
package lampfpu_sqrt_sched_pkg;

  localparam int LAMP_FLOAT_S_DW = 1;
  localparam int LAMP_FLOAT_E_DW = 8;
  localparam int LAMP_FLOAT_F_DW = 7;
  localparam int LAMP_FLOAT_DW   = LAMP_FLOAT_S_DW + LAMP_FLOAT_E_DW + LAMP_FLOAT_F_DW;

  // Exponent all ones, fraction MSB set: quiet NaN payload without the sign.
  localparam logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW-1:0] QNAN_E_F =
    {{LAMP_FLOAT_E_DW{1'b1}}, 1'b1, {(LAMP_FLOAT_F_DW-1){1'b0}}};

  // Canonical positive quiet NaN returned when the sqrt unit times out.
  localparam logic [LAMP_FLOAT_DW-1:0] LAMP_QNAN = {1'b0, QNAN_E_F};

  // Default issue-to-valid watchdog limit in cycles.
  localparam int LAMP_SQRT_TIMEOUT = 64;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_ISSUE = 2'd1,
    SCHED_WAIT  = 2'd2,
    SCHED_RESP  = 2'd3
  } sqrt_sched_state_t;

endpackage

// File: rtl/lampfpu_sqrt_sched_rr_arb.sv
// Combinational round-robin picker: returns the first requester at or after
// ptr_i (wrapping modulo N_REQ) as a one-hot grant plus its index.
module lampfpu_sqrt_sched_rr_arb #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  int pos;

  // Scan from the farthest offset down so the closest requester to ptr_i wins.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves
    // a value unassigned and no latch is inferred.
    gnt_o = '0;
    idx_o = '0;
    pos   = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      pos = (int'(ptr_i) + i) % N_REQ;
      if (req_i[pos]) begin
        gnt_o      = '0;
        gnt_o[pos] = 1'b1;
        idx_o      = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/lampfpu_sqrt_sched.sv
// Round-robin scheduler sharing one iterative sqrt / inverse-sqrt unit between
// N_REQ requesters, with an issue-to-valid watchdog that returns QNaN + error.
module lampfpu_sqrt_sched
  import lampfpu_sqrt_sched_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int DW          = LAMP_FLOAT_DW,
  parameter int TIMEOUT_CYC = LAMP_SQRT_TIMEOUT,
  parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req_i,
  input  logic [N_REQ-1:0]  inv_i,
  input  logic [N_REQ*DW-1:0] op_i,
  output logic [N_REQ-1:0]  gnt_o,
  output logic [N_REQ-1:0]  done_o,
  output logic [DW-1:0]     res_o,
  output logic              err_o,
  output logic              busy_o,
  output logic              doSqrt_o,
  output logic              doInvSqrt_o,
  output logic [DW-1:0]     op_o,
  input  logic [DW-1:0]     res_i,
  input  logic              valid_i
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sqrt_sched_state_t state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic              inv_q, inv_d;
  logic [DW-1:0]     op_q, op_d;
  logic [DW-1:0]     res_q, res_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  wdog_q, wdog_d;

  logic [N_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]  arb_idx;

  lampfpu_sqrt_sched_rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  // State and datapath registers; a reset aborts any in-flight operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SCHED_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      inv_q   <= 1'b0;
      op_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      wdog_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      inv_q   <= inv_d;
      op_q    <= op_d;
      res_q   <= res_d;
      err_q   <= err_d;
      wdog_q  <= wdog_d;
    end
  end

  // Next-state logic: pick and capture in IDLE, pulse in ISSUE, watch in WAIT.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    inv_d   = inv_q;
    op_d    = op_q;
    res_d   = res_q;
    err_d   = err_q;
    wdog_d  = wdog_q;
    unique case (state_q)
      SCHED_IDLE: begin
        if (|arb_gnt) begin
          owner_d = arb_idx;
          inv_d   = inv_i[arb_idx];
          op_d    = op_i[int'(arb_idx)*DW +: DW];
          state_d = SCHED_ISSUE;
        end
      end
      SCHED_ISSUE: begin
        ptr_d   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        wdog_d  = '0;
        state_d = SCHED_WAIT;
      end
      SCHED_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        // A valid arriving on the last watchdog cycle still wins.
        if (valid_i) begin
          res_d   = res_i;
          err_d   = 1'b0;
          state_d = SCHED_RESP;
        end else if (wdog_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          res_d   = DW'(LAMP_QNAN);
          err_d   = 1'b1;
          state_d = SCHED_RESP;
        end
      end
      SCHED_RESP: begin
        state_d = SCHED_IDLE;
      end
      default: begin
        state_d = SCHED_IDLE;
      end
    endcase
  end

  // Outputs decoded only from registered state: no input-to-output paths.
  assign gnt_o       = (state_q == SCHED_ISSUE) ? (N_REQ'(1) << owner_q) : '0;
  assign done_o      = (state_q == SCHED_RESP)  ? (N_REQ'(1) << owner_q) : '0;
  assign err_o       = (state_q == SCHED_RESP) && err_q;
  assign busy_o      = (state_q != SCHED_IDLE);
  assign doSqrt_o    = (state_q == SCHED_ISSUE) && !inv_q;
  assign doInvSqrt_o = (state_q == SCHED_ISSUE) && inv_q;
  assign op_o        = op_q;
  assign res_o       = res_q;

endmodule

// File: tb/tb_lampfpu_sqrt_sched.sv
// Self-checking bench for lampfpu_sqrt_sched: a cycle-stepped sqrt unit model
// plus a transaction-level scoreboard of grants, completion times and results.
`timescale 1ns/1ps
module tb_lampfpu_sqrt_sched;
  import lampfpu_sqrt_sched_pkg::*;

  localparam int N_REQ = 2;
  localparam int DW    = LAMP_FLOAT_DW;
  localparam int TMO   = LAMP_SQRT_TIMEOUT;

  logic              clk;
  logic              rst;
  logic [N_REQ-1:0]  req_i, inv_i;
  logic [N_REQ*DW-1:0] op_i;
  logic [N_REQ-1:0]  gnt_o, done_o;
  logic [DW-1:0]     res_o, op_o, res_i;
  logic              err_o, busy_o, doSqrt_o, doInvSqrt_o, valid_i;

  lampfpu_sqrt_sched #(.N_REQ(N_REQ)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .inv_i       (inv_i),
    .op_i        (op_i),
    .gnt_o       (gnt_o),
    .done_o      (done_o),
    .res_o       (res_o),
    .err_o       (err_o),
    .busy_o      (busy_o),
    .doSqrt_o    (doSqrt_o),
    .doInvSqrt_o (doInvSqrt_o),
    .op_o        (op_o),
    .res_i       (res_i),
    .valid_i     (valid_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            owner;
    int            done_cyc;
    logic [DW-1:0] res;
    logic          err;
  } pend_t;

  pend_t         pend[$];
  int            grant_log[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  int            m_ptr   = 0;
  int            grant_cnt = 0;
  bit            in_flight = 0;
  logic [DW-1:0] last_res = '0;
  int            unit_lat = 10;
  int            unit_cnt = 0;
  logic [DW-1:0] unit_res = '0;
  bit            manual_valid = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // bfloat16-style positive normal number to real.
  function automatic real bf2real(input logic [DW-1:0] b);
    real m;
    int  e;
    m = 1.0 + real'(int'(b[6:0])) / 128.0;
    e = int'(b[14:7]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return m;
  endfunction

  // Positive real to the same format, fraction truncated.
  function automatic logic [DW-1:0] real2bf(input real r);
    int         e;
    logic [7:0] ef;
    logic [6:0] ff;
    e = 127;
    while (r >= 2.0) begin r = r / 2.0; e++; end
    while (r < 1.0)  begin r = r * 2.0; e--; end
    ef = 8'(e);
    ff = 7'($rtoi((r - 1.0) * 128.0));
    return {1'b0, ef, ff};
  endfunction

  function automatic logic [DW-1:0] ref_unit(input logic [DW-1:0] op, input logic inv);
    real y;
    y = $sqrt(bf2real(op));
    if (inv) y = 1.0 / y;
    return real2bf(y);
  endfunction

  function automatic int pick(input logic [N_REQ-1:0] r, input int p);
    for (int i = 0; i < N_REQ; i++)
      if (r[(p + i) % N_REQ]) return (p + i) % N_REQ;
    return -1;
  endfunction

  // Advance one clock; run the sqrt unit model and the scoreboard on the new cycle.
  task automatic tick();
    logic [N_REQ-1:0]    req_s, inv_s;
    logic [N_REQ*DW-1:0] op_s;
    int    own;
    bit    done_now;
    pend_t rec;
    req_s = req_i;
    inv_s = inv_i;
    op_s  = op_i;
    @(posedge clk);
    #1;
    cyc++;
    valid_i = manual_valid;
    manual_valid = 0;
    if (unit_cnt > 0) begin
      unit_cnt--;
      if (unit_cnt == 0) begin
        valid_i = 1'b1;
        res_i   = unit_res;
      end
    end
    if (gnt_o != '0) begin
      own = pick(req_s, m_ptr);
      check("gnt_onehot", 32'(gnt_o), (own < 0) ? 32'd0 : (32'd1 << own));
      if (own < 0) own = 0;
      check("do_pulse", {30'd0, doInvSqrt_o, doSqrt_o}, inv_s[own] ? 32'd2 : 32'd1);
      check("op_issue", 32'(op_o), 32'(op_s[own*DW +: DW]));
      check("busy_start", 32'(busy_o), 32'd1);
      m_ptr = (own + 1) % N_REQ;
      grant_log.push_back(own);
      grant_cnt++;
      in_flight = 1;
      if (unit_lat > 0) begin
        unit_cnt = unit_lat;
        unit_res = ref_unit(op_o, doInvSqrt_o);
      end
      rec.owner = own;
      if (unit_lat >= 1 && unit_lat <= TMO) begin
        rec.done_cyc = cyc + unit_lat + 1;
        rec.res      = ref_unit(op_s[own*DW +: DW], inv_s[own]);
        rec.err      = 1'b0;
      end else begin
        rec.done_cyc = cyc + TMO + 1;
        rec.res      = LAMP_QNAN;
        rec.err      = 1'b1;
      end
      pend.push_back(rec);
    end else begin
      check("do_quiet", {30'd0, doInvSqrt_o, doSqrt_o}, 32'd0);
    end
    done_now = 0;
    if (pend.size() > 0 && cyc == pend[0].done_cyc) begin
      check("done_owner", 32'(done_o), 32'd1 << pend[0].owner);
      check("done_res", 32'(res_o), 32'(pend[0].res));
      check("done_err", 32'(err_o), 32'(pend[0].err));
      last_res = pend[0].res;
      void'(pend.pop_front());
      done_now = 1;
    end else begin
      check("done_quiet", 32'(done_o), 32'd0);
      check("err_quiet", 32'(err_o), 32'd0);
      check("res_hold", 32'(res_o), 32'(last_res));
    end
    check("busy", 32'(busy_o), 32'(in_flight));
    if (done_now) in_flight = 0;
  endtask

  task automatic wait_grant();
    int g0 = grant_cnt;
    for (int i = 0; i < 10 && grant_cnt == g0; i++) tick();
    check("grant_seen", grant_cnt, g0 + 1);
  endtask

  // Waits for all in-flight work while scrambling operands the DUT must ignore.
  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && pend.size() != 0; i++) begin
      op_i  = {$urandom, $urandom};
      inv_i = N_REQ'($urandom);
      tick();
    end
    check("done_seen", pend.size(), 0);
  endtask

  task automatic run_one(input logic [N_REQ-1:0] req, input logic [N_REQ-1:0] inv,
                         input logic [N_REQ*DW-1:0] op, input int lat);
    unit_lat = lat;
    req_i = req;
    inv_i = inv;
    op_i  = op;
    wait_grant();
    req_i = '0;
    wait_done(TMO + 20);
  endtask

  initial begin
    rst = 1'b0; req_i = '0; inv_i = '0; op_i = '0; res_i = '0; valid_i = 1'b0;
    #12;
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_res", 32'(res_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_do", {30'd0, doInvSqrt_o, doSqrt_o}, 32'd0);
    check("rst_op", 32'(op_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) tick();

    // Single sqrt of 4.0 from requester 0.
    run_one(2'b01, 2'b00, {16'h0, 16'h4080}, 10);
    check("sqrt4", 32'(res_o), 32'h4000);

    // Inverse sqrt of 4.0 from requester 1.
    run_one(2'b10, 2'b10, {16'h4080, 16'h0}, 10);
    check("invsqrt4", 32'(res_o), 32'h3F00);

    // Contention: both hold request for four operations.
    begin
      int g0 = grant_cnt;
      unit_lat = 6;
      req_i = 2'b11;
      inv_i = 2'b10;
      op_i  = {16'h4100, 16'h4080};
      for (int i = 0; i < 300 && grant_cnt < g0 + 4; i++) tick();
      req_i = '0;
      check("cont_grants", grant_cnt, g0 + 4);
      wait_done(TMO + 20);
      for (int i = 0; i < 4; i++) check("cont_order", grant_log[g0 + i], i % 2);
    end

    // Timeout, then a late valid that must be ignored.
    run_one(2'b01, 2'b00, {16'h0, 16'h4200}, 0);
    check("tmo_res", 32'(res_o), 32'h7FC0);
    res_i = 16'h1234;
    manual_valid = 1;
    repeat (4) tick();

    // Valid on the final watchdog cycle beats the timeout.
    run_one(2'b01, 2'b00, {16'h0, 16'h4080}, TMO);
    check("edge_res", 32'(res_o), 32'h4000);

    // Randomised operations with operand scrambling while busy.
    for (int n = 0; n < 16; n++) begin
      logic [N_REQ-1:0] r;
      r = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      run_one(r, N_REQ'($urandom),
              {1'b0, 8'($urandom_range(100, 150)), 7'($urandom),
               1'b0, 8'($urandom_range(100, 150)), 7'($urandom)},
              $urandom_range(1, 20));
      tick();
    end

    // Asynchronous reset in the middle of WAIT aborts with no completion.
    unit_lat = 0;
    req_i = 2'b01;
    op_i  = {16'h0, 16'h4080};
    wait_grant();
    req_i = '0;
    repeat (5) tick();
    rst = 1'b0;
    #1;
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_done", 32'(done_o), 32'd0);
    check("arst_res", 32'(res_o), 32'd0);
    check("arst_op", 32'(op_o), 32'd0);
    #4;
    rst = 1'b1;
    pend.delete();
    in_flight = 0;
    m_ptr = 0;
    unit_cnt = 0;
    last_res = '0;
    run_one(2'b11, 2'b00, {16'h4080, 16'h4100}, 5);
    check("post_rst_owner", grant_log[grant_log.size() - 1], 0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, observed time %0t", $time);
    $fatal(1, "bench time limit expired");
  end

endmodule

// File: doc/lampfpu_sqrt_sched.md
Name: lampFPU_sqrt_sched

Overview:
Round-robin scheduler that shares one iterative lampFPU square-root unit between N requesters. Each requester asks for either sqrt or inverse sqrt of one float word. The scheduler grants one requester at a time and issues a single-cycle doSqrt/doInvSqrt pulse with the operand. It then waits for the unit's valid, guarded by a watchdog, and returns the result to the owning requester with a done pulse. It sits between the lampFPU top-level operand decode and the sqrt datapath.

Parameters:
N_REQ, 2, number of requesters (2..8)
DW, LAMP_FLOAT_DW, float word width (S+E+F)
TIMEOUT_CYC, 64, max cycles from issue to unit valid before abort
CNT_W, $clog2(TIMEOUT_CYC+1), watchdog counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
req_i  in  N_REQ  per-requester level request
inv_i  in  N_REQ  per-requester op select: 0 = sqrt, 1 = inverse sqrt
op_i  in  N_REQ*DW  per-requester operand, slice k = op_i[k*DW +: DW]
gnt_o  out  N_REQ  one-hot accept pulse; operand is sampled this cycle
done_o  out  N_REQ  one-hot completion pulse
res_o  out  DW  result word, valid with done_o and held until next done
err_o  out  1  asserted with done_o when the operation timed out
busy_o  out  1  high in any state other than IDLE
doSqrt_o  out  1  single-cycle issue pulse to the sqrt unit
doInvSqrt_o  out  1  single-cycle issue pulse to the sqrt unit
op_o  out  DW  operand to the sqrt unit, held from ISSUE until next ISSUE
res_i  in  DW  sqrt unit packed result
valid_i  in  1  sqrt unit result valid

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; rr_ptr=0; all outputs 0; watchdog=0; owner=0.
- All outputs are registered or decoded from registered state. There are no combinational paths from inputs to outputs.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_i bit is set, select the first set bit scanning from rr_ptr upward, modulo N_REQ.
  - Register owner, inv and the operand, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - gnt_o[owner]=1.
  - doSqrt_o = ~inv; doInvSqrt_o = inv; exactly one of the two is high.
  - op_o = latched operand.
  - rr_ptr <= owner+1, wrapping to 0 at N_REQ.
  - Clear watchdog, then go to WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - If valid_i: capture res_i into res_o, err=0, go to RESP.
  - Else if watchdog == TIMEOUT_CYC-1: res_o = canonical QNaN from the package, err=1, go to RESP.
  - If valid_i and timeout occur in the same cycle, valid_i wins.
- RESP (exactly 1 cycle):
  - done_o[owner]=1; err_o=err.
  - Go to IDLE.
- Requester contract: deassert req_i in the cycle after gnt_o. A req_i still high in RESP is treated as a new request.
- Latency:
  - req_i sampled at edge t → gnt/do pulse in cycle t+1.
  - Sqrt unit valid at edge u → done_o in cycle u+1.
  - Minimum issue-to-issue spacing is the unit latency plus 3 cycles.
- valid_i in IDLE, ISSUE or RESP is ignored: no state change, no output.
- req_i changing while busy has no effect until the scheduler returns to IDLE.
- The operand is captured in IDLE; later changes to op_i do not affect the in-flight operation.
- Reset asserted mid-operation aborts the operation immediately with no done_o. The sqrt unit is reset by its own reset, driven from the same source.
- Fairness: with N_REQ requesters continuously asserting, each is granted once per N_REQ operations.

Decomposition:
- lampFPU_pkg gains:
  - LAMP_FLOAT_DW
  - the canonical QNaN word (reuse QNAN_E_F with sign 0)
  - the FSM state enum typedef sqrtSchedState_t
  - the default LAMP_SQRT_TIMEOUT constant
- One sub-module, lampFPU_rrArb: a pure combinational N-input round-robin priority picker. Inputs are req and ptr; outputs are the one-hot grant and its index. It is reusable for the div unit later.

Test Plan:
- Single sqrt: requester 0, req=1, inv=0, op=0x4080 (4.0), unit model latency 10 → gnt_o=01 at t+1, doSqrt_o one cycle, done_o=01 with res_o=0x4000, err_o=0.
- Inverse sqrt: requester 1, inv=1, op=0x4080 → doInvSqrt_o pulse only, done_o=10, res_o=0x3F00 (0.5).
- Contention: both requesters hold req continuously for 4 operations → grant order 0,1,0,1; no overlapping done pulses; busy_o stays high except the IDLE cycle between operations.
- Timeout: unit model never asserts valid → done_o after exactly TIMEOUT_CYC WAIT cycles, res_o=QNaN, err_o=1. A late valid_i afterwards is ignored.
- Same-cycle valid and timeout: valid_i on the last WAIT cycle → err_o=0, res_o=res_i.
- Async reset mid-WAIT: rst low for half a cycle → all outputs 0 immediately, no done_o. A new req after release is granted to requester 0.
